// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART pair: receiver state encoding
// and 8N1 frame constants used by both transmitter and receiver.
package wb_uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// is chosen per use so the output starts at the input's quiescent level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/wbs_uart_rx.sv
// Oversampling 8N1 UART receiver with a single holding register exposed
// through a read-only Wishbone slave, plus valid / frame-error / overrun flags.
module wbs_uart_rx
  import wb_uart_pkg::*;
#(
  parameter int TICKS_PER_BAUD = 4,
  parameter bit DATA_INVERT    = 1'b0
) (
  input  logic                      wbs_clk_i,
  input  logic                      wbs_rst_i,
  input  logic                      wbs_stb_i,
  output logic                      wbs_ack_o,
  output logic [UART_DATA_BITS-1:0] wbs_dat_o,
  input  logic                      uart_rx,
  output logic                      rx_valid_o,
  output logic                      rx_frame_err_o,
  output logic                      rx_overrun_o
);

  localparam int CW = $clog2(TICKS_PER_BAUD);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(TICKS_PER_BAUD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  uart_rx_state_e            state_q, state_d;
  logic [CW-1:0]             baud_cnt, cnt_d;
  logic [IW-1:0]             bit_idx, idx_d;
  logic [UART_DATA_BITS-1:0] shift_reg, hold;
  logic                      rx_s;
  logic                      shift_en, byte_done, frame_err_set, rd;

  sync_2ff #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (wbs_clk_i),
    .rst (wbs_rst_i),
    .d   (uart_rx),
    .q   (rx_s)
  );

  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = baud_cnt;
    idx_d         = bit_idx;
    shift_en      = 1'b0;
    byte_done     = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s == UART_START_BIT) state_d = START;
      end
      START: begin
        // Half-bit check rejects glitches and aligns later samples to mid-bit
        if (baud_cnt == HALF_M1) begin
          cnt_d = '0;
          if (rx_s == UART_START_BIT) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == LAST) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          idx_d    = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == LAST) begin
          cnt_d = '0;
          if (rx_s == UART_STOP_BIT) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          cnt_d = baud_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s == UART_IDLE_LEVEL) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rd = wbs_stb_i && !wbs_ack_o;

  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      baud_cnt       <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      hold           <= '0;
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      rx_overrun_o   <= 1'b0;
    end else begin
      baud_cnt  <= cnt_d;
      bit_idx   <= idx_d;
      wbs_ack_o <= rd;
      if (rd) wbs_dat_o <= hold;
      if (shift_en) shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
      if (byte_done) hold <= shift_reg ^ {UART_DATA_BITS{DATA_INVERT}};

      if (byte_done)  rx_valid_o <= 1'b1;
      else if (rd)    rx_valid_o <= 1'b0;

      if (frame_err_set) rx_frame_err_o <= 1'b1;
      else if (rd)       rx_frame_err_o <= 1'b0;

      // A byte completing on the read edge replaces one that is being consumed
      if (byte_done && rx_valid_o && !rd) rx_overrun_o <= 1'b1;
      else if (rd)                        rx_overrun_o <= 1'b0;
    end
  end

endmodule
